// File: rtl/maze_pkg.sv
// maze_pkg: definitions shared by the maze-generation blocks.
//
// Contents:
//   DIR_N/E/S/W  - 2-bit direction codes (0=N, 1=E, 2=S, 3=W). They are
//                  shared by the carver and by every user of the random stream.
//   state_t      - state encoding for the random-direction arbiter FSM.
//   clog2()      - ceiling log2, used to size counters and indices.
//
// No ports; this file is a package only.
package maze_pkg;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PICK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Smallest r such that 2**r >= value. clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) < value) begin
                result = r + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rand_dir_arbiter_if.sv
// rand_dir_arbiter_if: request/acknowledge bundle between the maze-logic
// requesters and the random-direction arbiter.
//
// Signals (NREQ = number of requesters):
//   req_i  [NREQ-1:0]   per-requester request level
//   mask_i [4*NREQ-1:0] legal-direction mask, requester k uses [4k+3:4k]
//   ack_o  [NREQ-1:0]   one-hot, single-cycle completion pulse
//   dir_o  [1:0]        chosen direction, valid while ack_o != 0
//   none_o              mask was empty, caller must backtrack
//   busy_o              arbiter is serving a request
//
// Modports: master = requester side, slave = arbiter side.
interface rand_dir_arbiter_if #(
    parameter int NREQ = 2
) ();

    logic [NREQ-1:0]   req_i;
    logic [4*NREQ-1:0] mask_i;
    logic [NREQ-1:0]   ack_o;
    logic [1:0]        dir_o;
    logic              none_o;
    logic              busy_o;

    modport master (
        output req_i, mask_i,
        input  ack_o, dir_o, none_o, busy_o
    );

    modport slave (
        input  req_i, mask_i,
        output ack_o, dir_o, none_o, busy_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin request picker.
//
// Picks the first set bit of req_i at or after ptr_i, wrapping modulo NREQ
// (also for non-power-of-two NREQ). The pointer register lives in the parent.
//
// Ports:
//   req_i [NREQ-1:0]  request vector
//   ptr_i [IDXW-1:0]  highest-priority index, must be < NREQ
//   gnt_o [NREQ-1:0]  one-hot grant, zero when no request is set
//   idx_o [IDXW-1:0]  encoded index of the grant, zero when none
module rr_arbiter
    import maze_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDXW-1:0] idx_o
);

    int              cand;
    logic [IDXW-1:0] cand_idx;
    logic            found;

    // Walk the requesters starting at the pointer; the first hit wins.
    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDXW'(cand);
            if (!found && req_i[cand_idx]) begin
                found           = 1'b1;
                gnt_o[cand_idx] = 1'b1;
                idx_o           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/rand_dir_arbiter.sv
// rand_dir_arbiter: shares the 2-bit random direction stream among NREQ
// requesters. Each request carries a 4-bit legal-direction mask; the block
// rejection-samples rand_i (one sample per cycle) until it lands on a legal
// direction and returns it with a one-hot ack. After MAX_TRIES misses the
// lowest legal direction (N>E>S>W) is returned instead. An empty mask is
// answered immediately with none_o. Requesters are served round-robin.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   rand_i [1:0]     random direction, new value every cycle
//   bus              rand_dir_arbiter_if.slave (req/mask in, ack/dir/none/busy out)
//   stat_miss_o      [15:0] saturating PICK-miss count   (RAND_DIR_STATS_EN only)
//   stat_fallback_o  [7:0]  saturating fallback count    (RAND_DIR_STATS_EN only)
//
// Optional build macro: RAND_DIR_STATS_EN adds the two statistics counters.
module rand_dir_arbiter
    import maze_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int MAX_TRIES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        rand_i,
`ifdef RAND_DIR_STATS_EN
    output logic [15:0]       stat_miss_o,
    output logic [7:0]        stat_fallback_o,
`endif
    rand_dir_arbiter_if.slave bus
);

    localparam int IDXW = clog2(NREQ);
    localparam int TRYW = clog2(MAX_TRIES + 1);

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] rr_q, rr_d;
    logic [IDXW-1:0] rr_next;
    logic [3:0]      mask_q, mask_d;
    logic [TRYW-1:0] try_q, try_d;
    logic [1:0]      dir_q, dir_d;
    logic            none_q, none_d;

    logic [NREQ-1:0] gnt;
    logic [IDXW-1:0] gnt_idx;
    logic [3:0]      mask_sel;
    logic [1:0]      fb_dir;
    logic            last_try;
    logic [NREQ-1:0] ack;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr (
        .req_i (bus.req_i),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    // Mask of the requester that would be granted this cycle.
    always_comb begin
        mask_sel = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                mask_sel = bus.mask_i[4*k +: 4];
            end
        end
    end

    // Deterministic fallback: lowest legal direction, N first.
    always_comb begin
        if (mask_q[DIR_N]) begin
            fb_dir = DIR_N;
        end else if (mask_q[DIR_E]) begin
            fb_dir = DIR_E;
        end else if (mask_q[DIR_S]) begin
            fb_dir = DIR_S;
        end else begin
            fb_dir = DIR_W;
        end
    end

    assign rr_next  = (idx_q == IDXW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
    assign last_try = (try_q == TRYW'(MAX_TRIES - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        mask_d  = mask_q;
        try_d   = try_q;
        dir_d   = dir_q;
        none_d  = none_q;
        case (state_q)
            ST_IDLE: begin
                dir_d  = DIR_N;
                none_d = 1'b0;
                if (|bus.req_i) begin
                    idx_d   = gnt_idx;
                    mask_d  = mask_sel;
                    try_d   = '0;
                    state_d = ST_PICK;
                end
            end
            ST_PICK: begin
                // A dropped request abandons the pick; the pointer stays put.
                if (!bus.req_i[idx_q]) begin
                    state_d = ST_IDLE;
                end else if (mask_q == 4'b0000) begin
                    none_d  = 1'b1;
                    dir_d   = DIR_N;
                    rr_d    = rr_next;
                    state_d = ST_DONE;
                end else if (mask_q[rand_i]) begin
                    dir_d   = rand_i;
                    rr_d    = rr_next;
                    state_d = ST_DONE;
                end else if (last_try) begin
                    try_d   = try_q + 1'b1;
                    dir_d   = fb_dir;
                    rr_d    = rr_next;
                    state_d = ST_DONE;
                end else begin
                    try_d = try_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rr_q    <= '0;
            mask_q  <= '0;
            try_q   <= '0;
            dir_q   <= DIR_N;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            mask_q  <= mask_d;
            try_q   <= try_d;
            dir_q   <= dir_d;
            none_q  <= none_d;
        end
    end

    // Results are only presented during the single DONE cycle.
    always_comb begin
        ack = '0;
        for (int k = 0; k < NREQ; k++) begin
            ack[k] = (state_q == ST_DONE) && (idx_q == IDXW'(k));
        end
    end

    assign bus.ack_o  = ack;
    assign bus.dir_o  = (state_q == ST_DONE) ? dir_q : DIR_N;
    assign bus.none_o = (state_q == ST_DONE) && none_q;
    assign bus.busy_o = (state_q != ST_IDLE);

`ifdef RAND_DIR_STATS_EN
    logic        pick_miss;
    logic        pick_fallback;
    logic [15:0] stat_miss_q, stat_miss_d;
    logic [7:0]  stat_fb_q, stat_fb_d;

    // A miss is a live PICK sample outside a non-empty mask.
    always_comb begin
        pick_miss     = (state_q == ST_PICK) && bus.req_i[idx_q] &&
                        (mask_q != 4'b0000) && !mask_q[rand_i];
        pick_fallback = pick_miss && last_try;
        stat_miss_d   = stat_miss_q;
        stat_fb_d     = stat_fb_q;
        if (pick_miss && (stat_miss_q != 16'hFFFF)) begin
            stat_miss_d = stat_miss_q + 16'd1;
        end
        if (pick_fallback && (stat_fb_q != 8'hFF)) begin
            stat_fb_d = stat_fb_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_miss_q <= '0;
            stat_fb_q   <= '0;
        end else begin
            stat_miss_q <= stat_miss_d;
            stat_fb_q   <= stat_fb_d;
        end
    end

    assign stat_miss_o     = stat_miss_q;
    assign stat_fallback_o = stat_fb_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/rand_dir_arbiter.md
Name: rand_dir_arbiter

Overview:
- Shares the 2-bit LFSR random stream (rand_num.rand) among NREQ maze-logic requesters, for example the carve FSM and the start-cell picker.
- Each request carries a 4-bit mask of legal neighbour directions.
- The block rejection-samples the random stream until it hits a legal direction, then returns that direction with a one-hot ack.
- After MAX_TRIES misses it falls back to a deterministic direction. Requesters are granted round-robin.

Parameters:
- NREQ, 2, number of requesters (2..8).
- MAX_TRIES, 8, random samples taken before the deterministic fallback (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rand_i  in  2  random direction from rand_num, new value every cycle
- req_i  in  NREQ  per-requester request level
- mask_i  in  4*NREQ  legal-direction mask; requester k uses bits [4k+3:4k]; bit d set means direction d is legal
- ack_o  out  NREQ  one-hot, single-cycle completion pulse
- dir_o  out  2  chosen direction, valid while ack_o != 0
- none_o  out  1  set with ack_o when the mask was 0000 (no legal direction; caller backtracks)
- busy_o  out  1  high in PICK and DONE

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; ack_o=0, dir_o=0, none_o=0, busy_o=0.
  - rr pointer=0, so requester 0 has first priority; try counter=0.
  - Reset mid-PICK abandons the request with no ack.
- Direction encoding: 0=N, 1=E, 2=S, 3=W.
- Requester rules:
  - Hold req_i high and mask_i stable until ack_o[k] is seen.
  - Drop req_i the cycle after ack, or re-request later.
- IDLE:
  - If any req_i bit is set, grant the first set bit at or after the rr pointer, wrapping modulo NREQ.
  - Latch idx and mask. Set try=0 and go to PICK.
- PICK (one sample per cycle):
  - If the latched mask is 0000 on the first PICK cycle: next cycle ack_o[idx]=1, none_o=1, dir_o=0.
  - Else if mask[rand_i]=1: next cycle ack_o[idx]=1 and dir_o=rand_i.
  - Else try=try+1. When try reaches MAX_TRIES, take the lowest set mask bit (N>E>S>W) and ack next cycle.
  - If req_i[idx] drops during PICK, return to IDLE with no ack. The rr pointer does not advance.
  - On every ack, go to DONE and set rr pointer = idx+1 mod NREQ.
- DONE: one-cycle cooldown.
  - ack_o is high in exactly this cycle; no new grant is made.
  - The next cycle returns to IDLE, and ack_o, none_o and dir_o return to 0.
- Latency:
  - req_i rises in cycle 0 (IDLE).
  - First hit gives ack in cycle 2.
  - Worst case (no hits) gives ack in cycle MAX_TRIES+1.
- Ordering and arbitration:
  - Simultaneous requests are served one at a time in rr order.
  - A request arriving during PICK or DONE waits.
  - Grant changes only in IDLE.
- Widths:
  - try counter is clog2(MAX_TRIES+1) bits and never wraps.
  - idx and rr pointer are clog2(NREQ) bits, wrapping at NREQ, including non-power-of-two values.

Optional Feature:
- Macro: RAND_DIR_STATS_EN
- Defined:
  - Adds output stat_miss_o[15:0], incremented on every PICK miss and saturating at 16'hFFFF.
  - Adds output stat_fallback_o[7:0], incremented on every fallback and saturating at 8'hFF.
  - Both are cleared by rst.
- Undefined: neither port nor its counters exists; all other behaviour is identical.

Decomposition:
- Shared package maze_pkg:
  - direction constants DIR_N/E/S/W = 0..3;
  - FSM state encoding ST_IDLE/ST_PICK/ST_DONE;
  - clog2 function.
  - The carver and rand_num users share the direction constants.
- Sub-module rr_arbiter:
  - input: NREQ-wide request vector and pointer;
  - output: one-hot grant plus encoded index;
  - purely combinational; the pointer register lives in the parent.

Test Plan:
- Single requester, mask 4'b1111: req_i[0]=1 at cycle 0 -> ack_o=01 at cycle 2, dir_o equals rand_i sampled at cycle 1, busy_o high cycles 1-2.
- Mask 4'b0000: req_i[1]=1 -> ack_o=10 with none_o=1 and dir_o=0 at cycle 2.
- Fallback: force rand_i=0, mask 4'b1010, MAX_TRIES=8 -> ack at cycle 9, dir_o=1 (E). With the macro, stat_fallback_o=1 and stat_miss_o=8.
- Round-robin: req_i=11 held continuously -> acks alternate 01, 10, 01, each separated by DONE and IDLE cycles.
- Abort and reset:
  - req_i[0] drops during PICK -> no ack, rr pointer unchanged, next grant goes to requester 0.
  - rst during PICK -> all outputs 0 on the next cycle.
- Randomized: with the real rand_num driving rand_i, 1000 requests with random non-zero masks -> dir_o always lies within the mask and exactly one ack per request.
